// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and the datapath mux blocks it steers.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      StRst     = 4'd0,
      StFetch   = 4'd1,
      StDecode  = 4'd2,
      StMemAddr = 4'd3,
      StMemRd   = 4'd4,
      StMemWb   = 4'd5,
      StMemWr   = 4'd6,
      StExecR   = 4'd7,
      StRWb     = 4'd8,
      StExecI   = 4'd9,
      StIWb     = 4'd10,
      StBranch  = 4'd11,
      StJump    = 4'd12,
      StIllegal = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [3:0] ALUSRCB_B      = 4'd0;
   localparam logic [3:0] ALUSRCB_FOUR   = 4'd1;
   localparam logic [3:0] ALUSRCB_SEXT   = 4'd2;
   localparam logic [3:0] ALUSRCB_SHIFT2 = 4'd3;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold for MEM_WAIT+1 cycles around a memory access.
   function automatic logic is_wait_state(input state_e s);
      return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with
// Moore-decoded datapath controls and a wait counter stretching every memory access.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [3:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       dwell_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StRst;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dwell_done = (cnt_q == WaitLast);
   assign state_dbg  = state_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = '0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALUSRCB_B;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;

      case (state_q)
         StRst: state_d = StFetch;
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = ALUSRCB_FOUR;
            // IR and PC only load once the memory word is actually available.
            if (dwell_done) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end
         end
         StDecode: begin
            alu_src_b = ALUSRCB_SHIFT2;
            case (opcode)
               OP_RTYPE:    state_d = StExecR;
               OP_ADDI:     state_d = StExecI;
               OP_LW, OP_SW: state_d = StMemAddr;
               OP_BEQ:      state_d = StBranch;
               OP_J:        state_d = StJump;
               default:     state_d = StIllegal;
            endcase
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUSRCB_SEXT;
            state_d   = (opcode == OP_LW) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (dwell_done) state_d = StMemWb;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (dwell_done) state_d = StFetch;
         end
         StExecR: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            state_d   = StRWb;
         end
         StRWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = StFetch;
         end
         StExecI: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUSRCB_SEXT;
            state_d   = StIWb;
         end
         StIWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            state_d       = StFetch;
         end
         StJump: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            state_d   = StFetch;
         end
         StIllegal: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
         end
         default: state_d = StFetch;
      endcase

      // Count only while dwelling; any transition (including MEM_WR -> FETCH) restarts at 0.
      if ((state_d == state_q) && is_wait_state(state_q)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: three instances with MEM_WAIT = 0, 2 and 3 share stimulus.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'h00;

   logic       pc_write [3];
   logic       pc_write_cond [3];
   logic       i_or_d [3];
   logic       mem_read [3];
   logic       mem_write [3];
   logic       ir_write [3];
   logic       reg_dst [3];
   logic       mem_to_reg [3];
   logic       reg_write [3];
   logic       alu_src_a [3];
   logic [3:0] alu_src_b [3];
   logic [1:0] alu_op [3];
   logic [1:0] pc_source [3];
   logic       illegal_op [3];
   logic [3:0] state_dbg [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mc_ctrl_fsm #(
         .MEM_WAIT((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) u_dut (
         .clk          (clk),
         .reset_n      (reset_n),
         .opcode       (opcode),
         .pc_write     (pc_write[g]),
         .pc_write_cond(pc_write_cond[g]),
         .i_or_d       (i_or_d[g]),
         .mem_read     (mem_read[g]),
         .mem_write    (mem_write[g]),
         .ir_write     (ir_write[g]),
         .reg_dst      (reg_dst[g]),
         .mem_to_reg   (mem_to_reg[g]),
         .reg_write    (reg_write[g]),
         .alu_src_a    (alu_src_a[g]),
         .alu_src_b    (alu_src_b[g]),
         .alu_op       (alu_op[g]),
         .pc_source    (pc_source[g]),
         .illegal_op   (illegal_op[g]),
         .state_dbg    (state_dbg[g])
      );
   end

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int exp_st[$];
   int n_mw, n_rw, n_il, n_ir, n_pw, n_iod, ir_first;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   function automatic logic [18:0] outs(input int g);
      return {pc_write[g], pc_write_cond[g], i_or_d[g], mem_read[g], mem_write[g],
              ir_write[g], reg_dst[g], mem_to_reg[g], reg_write[g], alu_src_a[g],
              alu_src_b[g], alu_op[g], pc_source[g], illegal_op[g]};
   endfunction

   // Steps through exp_st, checking the state each cycle plus the key controls of that state.
   task automatic walk(input int g, input string tag);
      n_mw = 0; n_rw = 0; n_il = 0; n_ir = 0; n_pw = 0; n_iod = 0; ir_first = -1;
      foreach (exp_st[k]) begin
         check($sformatf("%s_state%0d", tag, k), 32'(state_dbg[g]), 32'(exp_st[k]));
         n_mw  += int'(mem_write[g]);
         n_rw  += int'(reg_write[g]);
         n_il  += int'(illegal_op[g]);
         n_pw  += int'(pc_write[g]);
         n_iod += int'(i_or_d[g]);
         if (ir_write[g]) begin
            n_ir++;
            if (ir_first < 0) ir_first = k;
         end
         case (exp_st[k])
            2: check({tag, "_dec_srcb"}, 32'(alu_src_b[g]), 32'd3);
            4: check({tag, "_memrd_rd"}, 32'({mem_read[g], i_or_d[g]}), 32'b11);
            5: check({tag, "_memwb"}, 32'({reg_write[g], reg_dst[g], mem_to_reg[g]}), 32'b101);
            6: check({tag, "_memwr_iod"}, 32'(i_or_d[g]), 32'd1);
            7: check({tag, "_execr"}, 32'({alu_src_a[g], alu_src_b[g], alu_op[g]}),
                     32'b1_0000_10);
            8: check({tag, "_rwb"}, 32'({reg_write[g], reg_dst[g], mem_to_reg[g]}), 32'b110);
            11: check({tag, "_branch"},
                      32'({pc_write_cond[g], pc_source[g], alu_op[g], alu_src_b[g]}),
                      32'b1_01_01_0000);
            12: check({tag, "_jump"}, 32'({pc_write[g], pc_source[g]}), 32'b1_10);
            default: ;
         endcase
         tick();
      end
   endtask

   initial begin
      // Reset held across three edges
      reset_n = 1'b0;
      opcode  = OP_RTYPE;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         check($sformatf("rst_state_i%0d", g), 32'(state_dbg[g]), 32'd0);
         check($sformatf("rst_outs_i%0d", g), 32'(outs(g)), 32'd0);
      end
      reset_n = 1'b1;
      tick();
      for (int g = 0; g < 3; g++) begin
         check($sformatf("fetch_entry_i%0d", g),
               32'({state_dbg[g], mem_read[g], alu_src_b[g]}), 32'b0001_1_0001);
      end

      // R-type, MEM_WAIT = 0 (instance 0 is at its first FETCH cycle)
      exp_st = '{1, 2, 7, 8, 1};
      walk(0, "rtype");
      check("rtype_ir_first", 32'(ir_first), 32'd0);
      check("rtype_pw_count", 32'(n_pw), 32'd2);

      // lw, MEM_WAIT = 2
      opcode = OP_LW;
      restart();
      exp_st = '{1, 1, 1, 2, 3, 4, 4, 4, 5, 1};
      walk(1, "lw");
      check("lw_ir_first", 32'(ir_first), 32'd2);
      check("lw_ir_count", 32'(n_ir), 32'd1);
      check("lw_iod_count", 32'(n_iod), 32'd3);

      // sw followed by beq, MEM_WAIT = 2
      opcode = OP_SW;
      restart();
      exp_st = '{1, 1, 1, 2, 3, 6, 6, 6};
      walk(1, "sw");
      check("sw_mw_count", 32'(n_mw), 32'd3);
      check("sw_rw_count", 32'(n_rw), 32'd0);
      opcode = OP_BEQ;
      exp_st = '{1, 1, 1, 2, 11, 1};
      walk(1, "beq");
      check("beq_rw_count", 32'(n_rw), 32'd0);

      // Illegal opcode then j, MEM_WAIT = 0
      opcode = 6'h3F;
      restart();
      exp_st = '{1, 2, 13};
      walk(0, "ill");
      check("ill_pulse_count", 32'(n_il), 32'd1);
      opcode = OP_J;
      exp_st = '{1, 2, 12, 1};
      walk(0, "jmp");
      check("jmp_ill_count", 32'(n_il), 32'd0);

      // Reset dropped mid-MEM_RD, MEM_WAIT = 3
      opcode = OP_LW;
      restart();
      exp_st = '{1, 1, 1, 1, 2, 3, 4};
      walk(2, "abort");
      check("abort_in_memrd", 32'(state_dbg[2]), 32'd4);
      reset_n = 1'b0;
      #1;
      check("abort_state", 32'(state_dbg[2]), 32'd0);
      check("abort_outs", 32'(outs(2)), 32'd0);
      reset_n = 1'b1;
      tick();
      exp_st = '{1, 1, 1, 1, 2};
      walk(2, "refetch");
      check("refetch_ir_first", 32'(ir_first), 32'd3);
      check("refetch_ir_count", 32'(n_ir), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
